// File: rtl/div_if.sv
// DIV request/result bundle between EX and the divider.
// EX drives the request side, the divider returns the registered result.
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; signed mode uses magnitude + fix-up.
module div (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] work_q, work_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [31:0] op1_mag, op2_mag;
   logic [64:0] shifted;
   logic [32:0] diff;
   logic [31:0] quo_fix, rem_fix;

   // Operand magnitudes, trial subtraction and final sign fix-up
   always_comb begin
      op1_mag = (bus.signed_div_i && bus.opdata1_i[31]) ?
                (32'd0 - bus.opdata1_i) : bus.opdata1_i;
      op2_mag = (bus.signed_div_i && bus.opdata2_i[31]) ?
                (32'd0 - bus.opdata2_i) : bus.opdata2_i;
      shifted = work_q << 1;
      diff    = shifted[64:32] - {1'b0, dvsr_q};
      quo_fix = qneg_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
      rem_fix = rneg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvsr_d   = dvsr_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = 64'h0;
      ready_d  = 1'b0;
      unique case (state_q)
         FREE: begin
            if (bus.start_i && !bus.annul_i) begin
               cnt_d  = 6'd0;
               work_d = {33'd0, op1_mag};
               dvsr_d = op2_mag;
               qneg_d = bus.signed_div_i &
                        (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
               rneg_d = bus.signed_div_i & bus.opdata1_i[31];
               state_d = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
            end
         end
         BYZERO: begin
            if (bus.annul_i) begin
               state_d = FREE;
            end else begin
               state_d = END;
               ready_d = 1'b1;
            end
         end
         ON: begin
            if (bus.annul_i) begin
               state_d = FREE;
               cnt_d   = 6'd0;
            end else if (cnt_q == 6'd32) begin
               state_d  = END;
               ready_d  = 1'b1;
               result_d = {rem_fix, quo_fix};
            end else begin
               cnt_d  = cnt_q + 6'd1;
               work_d = diff[32] ? shifted
                                 : {diff, shifted[31:1], 1'b1};
            end
         end
         END: begin
            if (bus.start_i) begin
               ready_d  = 1'b1;
               result_d = result_q;
            end else begin
               state_d = FREE;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FREE;
         cnt_q    <= 6'd0;
         work_q   <= 65'd0;
         dvsr_q   <= 32'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= 64'h0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         dvsr_q   <= dvsr_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Bench for div: scoreboard of expected results, one task per scenario.
// Latency is counted in edges from the accepting edge (edge 1).
module tb_div;

   logic clk;
   logic rst;
   div_if bus ();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [63:0] sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic sgn,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb_, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'h0;
      if (sgn) begin
         sa  = longint'($signed(a));
         sb_ = longint'($signed(b));
      end else begin
         sa  = longint'({32'd0, a});
         sb_ = longint'({32'd0, b});
      end
      q  = sa / sb_;
      r  = sa % sb_;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   // Drive a request; returns just after edge 1 with operands scrambled
   task automatic start_req(input logic sgn, input logic [31:0] a,
                            input logic [31:0] b);
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b0;
      @(posedge clk);
      #1;
      bus.signed_div_i = ~sgn;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
   endtask

   task automatic wait_ready(output int lat, output logic [63:0] res);
      lat = -1;
      res = 64'h0;
      for (int i = 2; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) begin
            lat = i;
            res = bus.result_o;
            break;
         end
      end
   endtask

   task automatic release_start();
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_i = 1'b1;
      bus.annul_i = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.ready_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready got=%b want=0", bus.ready_o);
      end
      total++;
      if (bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL reset_result got=%h want=0", bus.result_o);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_unsigned();
      int lat;
      logic [63:0] res, exp;
      sb.push_back({32'd2, 32'd14});
      start_req(1'b0, 32'd100, 32'd7);
      wait_ready(lat, res);
      exp = sb.pop_front();
      total++;
      if (lat !== 34) begin
         bad++;
         $display("FAIL udiv_latency got=%0d want=34", lat);
      end
      total++;
      if (res !== exp) begin
         bad++;
         $display("FAIL udiv_result got=%h want=%h", res, exp);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
            bad++;
            $display("FAIL udiv_hold got=%b/%h want=1/%h",
                     bus.ready_o, bus.result_o, exp);
         end
      end
      release_start();
      total++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL udiv_exit got=%b/%h want=0/0",
                  bus.ready_o, bus.result_o);
      end
   endtask

   task automatic test_signed_vectors();
      logic        sg[4];
      logic [31:0] va[4], vb[4];
      logic [63:0] ve[4];
      int lat;
      logic [63:0] res, exp;
      sg[0] = 1; va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
      ve[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
      sg[1] = 1; va[1] = 32'd7; vb[1] = 32'hFFFFFFFE;
      ve[1] = {32'd1, 32'hFFFFFFFD};
      sg[2] = 1; va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF;
      ve[2] = {32'h0, 32'h80000000};
      sg[3] = 0; va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF;
      ve[3] = {32'h80000000, 32'h0};
      for (int i = 0; i < 4; i++) begin
         sb.push_back(ve[i]);
         start_req(sg[i], va[i], vb[i]);
         wait_ready(lat, res);
         exp = sb.pop_front();
         total++;
         if (lat !== 34 || res !== exp) begin
            bad++;
            $display("FAIL vec%0d got=%0d/%h want=34/%h",
                     i, lat, res, exp);
         end
         release_start();
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [63:0] res, exp;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(64'h0);
         start_req(i[0], 32'hDEADBEEF, 32'd0);
         wait_ready(lat, res);
         exp = sb.pop_front();
         total++;
         if (lat !== 2 || res !== exp) begin
            bad++;
            $display("FAIL divzero%0d got=%0d/%h want=2/%h",
                     i, lat, res, exp);
         end
         release_start();
      end
   endtask

   task automatic test_annul();
      int lat;
      int seen;
      logic [63:0] res, exp;
      start_req(1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      bus.annul_i = 1'b0;
      total++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL annul_free got=%b/%h want=0/0",
                  bus.ready_o, bus.result_o);
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL annul_noready got=%0d want=0", seen);
      end
      sb.push_back({32'd0, 32'd3});
      start_req(1'b0, 32'd9, 32'd3);
      wait_ready(lat, res);
      exp = sb.pop_front();
      total++;
      if (lat !== 34 || res !== exp) begin
         bad++;
         $display("FAIL annul_next got=%0d/%h want=34/%h",
                  lat, res, exp);
      end
      release_start();
   endtask

   task automatic test_rst_mid();
      int lat;
      logic [63:0] res, exp;
      start_req(1'b0, 32'd100, 32'd7);
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL rst_mid got=%b/%h want=0/0",
                  bus.ready_o, bus.result_o);
      end
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL rst_hold got=%b/%h want=0/0",
                  bus.ready_o, bus.result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.start_i = 1'b0;
      sb.push_back({32'd0, 32'd100});
      start_req(1'b0, 32'd1000, 32'd10);
      wait_ready(lat, res);
      exp = sb.pop_front();
      total++;
      if (lat !== 34 || res !== exp) begin
         bad++;
         $display("FAIL rst_fresh got=%0d/%h want=34/%h",
                  lat, res, exp);
      end
      release_start();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [63:0] res, exp;
      sb.push_back(model(1'b1, 32'hFFFFFF9C, 32'd7));
      start_req(1'b1, 32'hFFFFFF9C, 32'd7);
      wait_ready(lat, res);
      exp = sb.pop_front();
      total++;
      if (lat !== 34 || res !== exp) begin
         bad++;
         $display("FAIL b2b_first got=%0d/%h want=34/%h",
                  lat, res, exp);
      end
      @(negedge clk);
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      bus.annul_i = 1'b0;
      total++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
         bad++;
         $display("FAIL end_annul got=%b/%h want=1/%h",
                  bus.ready_o, bus.result_o, exp);
      end
      release_start();
      total++;
      if (bus.ready_o !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap got=%b want=0", bus.ready_o);
      end
      sb.push_back(model(1'b0, 32'hFFFFFFFF, 32'd16));
      start_req(1'b0, 32'hFFFFFFFF, 32'd16);
      wait_ready(lat, res);
      exp = sb.pop_front();
      total++;
      if (lat !== 34 || res !== exp) begin
         bad++;
         $display("FAIL b2b_second got=%0d/%h want=34/%h",
                  lat, res, exp);
      end
      release_start();
   endtask

   task automatic test_random();
      int lat;
      logic sg;
      logic [31:0] a, b;
      logic [63:0] res, exp;
      for (int i = 0; i < 8; i++) begin
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i == 7) b = 32'd1;
         sb.push_back(model(sg, a, b));
         start_req(sg, a, b);
         wait_ready(lat, res);
         exp = sb.pop_front();
         total++;
         if (lat !== 34 || res !== exp) begin
            bad++;
            $display("FAIL rand%0d s=%b %h/%h got=%0d/%h want=34/%h",
                     i, sg, a, b, lat, res, exp);
         end
         release_start();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i = 32'd0;
      bus.opdata2_i = 32'd0;
      test_reset();
      test_unsigned();
      test_signed_vectors();
      test_div_zero();
      test_annul();
      test_rst_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
